multicycle_controller: RTL and testbench
========================================

MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

Interface
REQ-001 SHALL have parameter ALU_CTRL_W, default 3: ALUControl width; must be >=3; bits above [2:0] are driven 0.
REQ-002 SHALL have parameter MEM_TIMEOUT, default 15: maximum cycles spent waiting on mem_ready before abort; range 1..255.
REQ-003 SHALL have ports, in this order:
- clk  in  1  — single clock, rising edge.
- reset  in  1  — asynchronous, active-high.
- op  in  7  — instruction opcode.
- funct3  in  3  — instruction funct3.
- funct7  in  7  — instruction funct7.
- Zero  in  1  — ALU zero flag.
- mem_ready  in  1  — memory access completes this cycle.
- PCWrite  out  1  — PC register enable.
- AdrSrc  out  1  — memory address select: 0 = PC, 1 = ALUOut.
- MemWrite  out  1  — memory write strobe.
- IRWrite  out  1  — IR and OldPC enable.
- RegWrite  out  1  — register file write.
- ResultSrc  out  2  — result select: 00 = ALUOut, 01 = Data, 10 = ALUResult.
- ALUSrcA  out  2  — A operand select: 00 = PC, 01 = OldPC, 10 = rs1.
- ALUSrcB  out  2  — B operand select: 00 = rs2, 01 = imm, 10 = constant 4.
- ImmSrc  out  2  — immediate format: 00 = I, 01 = S, 10 = B, 11 = J.
- ALUControl  out  ALU_CTRL_W  — ALU operation.
- illegal_instr  out  1  — unsupported opcode decoded.
- mem_fault  out  1  — memory wait timed out.

Function
REQ-004 SHALL be a Moore FSM. States: FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI, ALUWB, BEQ, JAL. Only mem_ready-gated strobes and BEQ's PCWrite depend on inputs.
REQ-005 ALUControl encodings SHALL be: and=000, or=001, add=010, sub=110, slt=111.
REQ-006 FETCH: AdrSrc=0, ALUSrcA=00, ALUSrcB=10, add, ResultSrc=10.
- IRWrite=PCWrite=mem_ready.
- Next state is DECODE on mem_ready; otherwise remain in FETCH.
REQ-007 DECODE: ALUSrcA=01, ALUSrcB=01, add. Next state by op:
- 0000011 or 0100011 -> MEMADR.
- 0110011 -> EXECR.
- 0010011 -> EXECI.
- 1100011 -> BEQ.
- 1101111 -> JAL.
- any other op -> illegal_instr=1 this cycle, then FETCH.
REQ-008 MEMADR: ALUSrcA=10, ALUSrcB=01, add. Next state is MEMREAD for lw, MEMWRITE for sw.
REQ-009 MEMREAD: AdrSrc=1, ResultSrc=00. Next state is MEMWB on mem_ready.
REQ-010 MEMWRITE: AdrSrc=1, MemWrite=1 held until mem_ready. Next state is FETCH on mem_ready.
REQ-011 MEMWB: ResultSrc=01, RegWrite=1. Next state is FETCH.
REQ-012 EXECR: ALUSrcA=10, ALUSrcB=00, ALUControl per REQ-005 from funct3/funct7[5] (000 with funct7[5]=1 -> sub). Next state is ALUWB.
REQ-013 EXECI: ALUSrcA=10, ALUSrcB=01, ALUControl from funct3 only (000 -> add; funct7 ignored). Next state is ALUWB.
REQ-014 ALUWB: ResultSrc=00, RegWrite=1. Next state is FETCH.
REQ-015 BEQ: ALUSrcA=10, ALUSrcB=00, sub, ResultSrc=00, PCWrite=Zero. Next state is FETCH.
REQ-016 JAL: ALUSrcA=01, ALUSrcB=10, add, ResultSrc=00, PCWrite=1. Next state is ALUWB.
REQ-017 ImmSrc SHALL be decoded combinationally from op in every state: lw/addi -> 00, sw -> 01, branch -> 10, jal -> 11, other -> 00.
REQ-018 Outputs not listed for a state SHALL be 0; no output may be X.
REQ-019 Wait counter:
- Increments each cycle spent in FETCH, MEMREAD or MEMWRITE with mem_ready=0.
- Clears on any state change.
- Reaching MEM_TIMEOUT forces FETCH next, with mem_fault=1 for exactly one cycle (registered).
- On abort, MemWrite drops and no RegWrite occurs.
REQ-020 Timeout and mem_ready in the same cycle: mem_ready wins; normal transition, no fault.

Reset
REQ-021 Reset SHALL asynchronously force state FETCH, counter 0, mem_fault 0. While reset is asserted, all strobes are 0 and ALUControl=010.
REQ-022 Reset mid-access SHALL abort immediately; MemWrite deasserts within the same cycle.

Configuration
REQ-023 With macro CTRL_BNE_EN defined, a branch with funct3=001 SHALL use BEQ with PCWrite=~Zero. Without it, any branch funct3 other than 000 is illegal per REQ-007.

Structure
REQ-024 Package mc_ctrl_pkg SHALL hold: the state enum, ALUControl codes, opcode constants, and the ResultSrc/ALUSrcA/ALUSrcB/ImmSrc encodings.
REQ-025 ALU decoding SHALL live in combinational sub-module alu_decoder.

Verification
REQ-026 lw (op=0000011, funct3=010), mem_ready always 1 -> FETCH, DECODE, MEMADR, MEMREAD, MEMWB: 5 cycles. MEMWB shows RegWrite=1, ResultSrc=01.
REQ-027 sub (op=0110011, funct3=000, funct7=0100000) -> EXECR shows ALUControl=110; ALUWB shows RegWrite=1.
REQ-028 beq, Zero=1 then Zero=0 -> PCWrite=1 in BEQ for the first, 0 for the second. With CTRL_BNE_EN, bne gives the inverse.
REQ-029 sw with mem_ready low for 3 cycles -> MemWrite held 4 cycles; MEM_TIMEOUT=2 -> mem_fault pulse, return to FETCH, no further MemWrite.
REQ-030 op=1110011 -> illegal_instr=1 in DECODE, FETCH next. Reset asserted during MEMREAD -> FETCH, all strobes 0 asynchronously.

Source files
------------

// File: rtl/mc_ctrl_pkg.sv
// Shared types and encodings for the multicycle RISC-V controller.
// Holds the FSM state enum, ALU codes, opcodes and datapath mux encodings.
package mc_ctrl_pkg;

  typedef enum logic [3:0] {
    FETCH,
    DECODE,
    MEMADR,
    MEMREAD,
    MEMWB,
    MEMWRITE,
    EXECR,
    EXECI,
    ALUWB,
    BEQ,
    JAL
  } state_e;

  // How the ALU decoder should derive the operation for the current state
  typedef enum logic [2:0] {
    ALU_MODE_ZERO,
    ALU_MODE_ADD,
    ALU_MODE_SUB,
    ALU_MODE_RTYPE,
    ALU_MODE_ITYPE
  } alu_mode_e;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  localparam logic [6:0] OP_LW     = 7'b0000011;
  localparam logic [6:0] OP_SW     = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

  function automatic logic [1:0] imm_src_for(input logic [6:0] op);
    case (op)
      OP_LW, OP_ITYPE: imm_src_for = IMM_I;
      OP_SW:           imm_src_for = IMM_S;
      OP_BRANCH:       imm_src_for = IMM_B;
      OP_JAL:          imm_src_for = IMM_J;
      default:         imm_src_for = IMM_I;
    endcase
  endfunction

endpackage

// File: rtl/alu_decoder.sv
// Combinational ALU operation decoder for the multicycle controller.
// Fixed modes come from the FSM; R/I modes decode funct3 (and funct7[5] for R).
module alu_decoder
  import mc_ctrl_pkg::*;
(
  input  alu_mode_e   mode,
  input  logic [2:0]  funct3,
  input  logic        funct7b5,
  output logic [2:0]  alu_ctrl
);

  always_comb begin
    alu_ctrl = ALU_AND;
    case (mode)
      ALU_MODE_ZERO: alu_ctrl = ALU_AND;
      ALU_MODE_ADD:  alu_ctrl = ALU_ADD;
      ALU_MODE_SUB:  alu_ctrl = ALU_SUB;
      ALU_MODE_RTYPE, ALU_MODE_ITYPE: begin
        case (funct3)
          // Only register-register ops can select subtract through funct7
          3'b000:  alu_ctrl = (mode == ALU_MODE_RTYPE && funct7b5) ? ALU_SUB : ALU_ADD;
          3'b010:  alu_ctrl = ALU_SLT;
          3'b110:  alu_ctrl = ALU_OR;
          3'b111:  alu_ctrl = ALU_AND;
          default: alu_ctrl = ALU_ADD;
        endcase
      end
      default: alu_ctrl = ALU_AND;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Moore FSM controller for a multicycle RISC-V datapath with memory wait timeout.
// Optional macro CTRL_BNE_EN adds bne (branch funct3=001) through the BEQ state.
module multicycle_controller
  import mc_ctrl_pkg::*;
#(
  parameter int ALU_CTRL_W  = 3,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [6:0]            op,
  input  logic [2:0]            funct3,
  input  logic [6:0]            funct7,
  input  logic                  Zero,
  input  logic                  mem_ready,
  output logic                  PCWrite,
  output logic                  AdrSrc,
  output logic                  MemWrite,
  output logic                  IRWrite,
  output logic                  RegWrite,
  output logic [1:0]            ResultSrc,
  output logic [1:0]            ALUSrcA,
  output logic [1:0]            ALUSrcB,
  output logic [1:0]            ImmSrc,
  output logic [ALU_CTRL_W-1:0] ALUControl,
  output logic                  illegal_instr,
  output logic                  mem_fault
);

  localparam logic [7:0] TIMEOUT_LAST = 8'(MEM_TIMEOUT - 1);

  state_e     state;
  state_e     state_next;
  logic [7:0] wait_cnt;
  logic       waiting;
  logic       timeout;
  logic       pc_w;
  logic       mem_w;
  logic       ir_w;
  logic       reg_w;
  alu_mode_e  alu_mode;
  logic [2:0] alu_ctrl;
  logic       unused_funct7;

  assign unused_funct7 = ^{funct7[6], funct7[4:0]};

  // A memory wait is any cycle in a memory-facing state without mem_ready;
  // mem_ready in the final allowed cycle still wins over the abort.
  assign waiting = (state == FETCH || state == MEMREAD || state == MEMWRITE) && !mem_ready;
  assign timeout = waiting && (wait_cnt == TIMEOUT_LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= FETCH;
      wait_cnt  <= 8'd0;
      mem_fault <= 1'b0;
    end else begin
      state     <= state_next;
      mem_fault <= timeout;
      if (timeout || state_next != state)
        wait_cnt <= 8'd0;
      else if (waiting)
        wait_cnt <= wait_cnt + 8'd1;
    end
  end

  always_comb begin
    state_next    = state;
    pc_w          = 1'b0;
    mem_w         = 1'b0;
    ir_w          = 1'b0;
    reg_w         = 1'b0;
    AdrSrc        = 1'b0;
    ResultSrc     = RES_ALUOUT;
    ALUSrcA       = SRCA_PC;
    ALUSrcB       = SRCB_RS2;
    alu_mode      = ALU_MODE_ZERO;
    illegal_instr = 1'b0;
    case (state)
      FETCH: begin
        ALUSrcB   = SRCB_FOUR;
        alu_mode  = ALU_MODE_ADD;
        ResultSrc = RES_ALURESULT;
        ir_w      = mem_ready;
        pc_w      = mem_ready;
        if (mem_ready)
          state_next = DECODE;
      end
      DECODE: begin
        ALUSrcA  = SRCA_OLDPC;
        ALUSrcB  = SRCB_IMM;
        alu_mode = ALU_MODE_ADD;
        case (op)
          OP_LW, OP_SW: state_next = MEMADR;
          OP_RTYPE:     state_next = EXECR;
          OP_ITYPE:     state_next = EXECI;
          OP_JAL:       state_next = JAL;
          OP_BRANCH: begin
            if (funct3 == 3'b000)
              state_next = BEQ;
`ifdef CTRL_BNE_EN
            else if (funct3 == 3'b001)
              state_next = BEQ;
`endif
            else begin
              illegal_instr = 1'b1;
              state_next    = FETCH;
            end
          end
          default: begin
            illegal_instr = 1'b1;
            state_next    = FETCH;
          end
        endcase
      end
      MEMADR: begin
        ALUSrcA    = SRCA_RS1;
        ALUSrcB    = SRCB_IMM;
        alu_mode   = ALU_MODE_ADD;
        state_next = (op == OP_LW) ? MEMREAD : MEMWRITE;
      end
      MEMREAD: begin
        AdrSrc    = 1'b1;
        ResultSrc = RES_ALUOUT;
        if (mem_ready)
          state_next = MEMWB;
      end
      MEMWRITE: begin
        AdrSrc = 1'b1;
        mem_w  = 1'b1;
        if (mem_ready)
          state_next = FETCH;
      end
      MEMWB: begin
        ResultSrc  = RES_DATA;
        reg_w      = 1'b1;
        state_next = FETCH;
      end
      EXECR: begin
        ALUSrcA    = SRCA_RS1;
        ALUSrcB    = SRCB_RS2;
        alu_mode   = ALU_MODE_RTYPE;
        state_next = ALUWB;
      end
      EXECI: begin
        ALUSrcA    = SRCA_RS1;
        ALUSrcB    = SRCB_IMM;
        alu_mode   = ALU_MODE_ITYPE;
        state_next = ALUWB;
      end
      ALUWB: begin
        ResultSrc  = RES_ALUOUT;
        reg_w      = 1'b1;
        state_next = FETCH;
      end
      BEQ: begin
        ALUSrcA    = SRCA_RS1;
        ALUSrcB    = SRCB_RS2;
        alu_mode   = ALU_MODE_SUB;
        ResultSrc  = RES_ALUOUT;
`ifdef CTRL_BNE_EN
        pc_w       = (funct3 == 3'b001) ? ~Zero : Zero;
`else
        pc_w       = Zero;
`endif
        state_next = FETCH;
      end
      JAL: begin
        ALUSrcA    = SRCA_OLDPC;
        ALUSrcB    = SRCB_FOUR;
        alu_mode   = ALU_MODE_ADD;
        ResultSrc  = RES_ALUOUT;
        pc_w       = 1'b1;
        state_next = ALUWB;
      end
      default: state_next = FETCH;
    endcase
    // An expired memory wait abandons the access and refetches
    if (timeout)
      state_next = FETCH;
  end

  // Strobes are masked by reset directly so an in-flight write drops immediately
  assign PCWrite  = pc_w  & ~reset;
  assign MemWrite = mem_w & ~reset;
  assign IRWrite  = ir_w  & ~reset;
  assign RegWrite = reg_w & ~reset;
  assign ImmSrc   = imm_src_for(op);

  alu_decoder u_alu_decoder (
    .mode     (alu_mode),
    .funct3   (funct3),
    .funct7b5 (funct7[5]),
    .alu_ctrl (alu_ctrl)
  );

  always_comb begin
    ALUControl      = '0;
    ALUControl[2:0] = alu_ctrl;
  end

endmodule

// File: tb/tb_multicycle_controller.sv
// Scoreboard testbench for multicycle_controller (MEM_TIMEOUT=4 instance).
// Driver queues hand-computed per-cycle outputs; a negedge monitor compares them.
module tb_multicycle_controller;

  localparam logic [6:0] LW   = 7'b0000011;
  localparam logic [6:0] SW   = 7'b0100011;
  localparam logic [6:0] RT   = 7'b0110011;
  localparam logic [6:0] IT   = 7'b0010011;
  localparam logic [6:0] BR   = 7'b1100011;
  localparam logic [6:0] JL   = 7'b1101111;
  localparam logic [6:0] SYS  = 7'b1110011;
  localparam logic [6:0] F7S  = 7'b0100000;

  typedef struct {
    logic [17:0] vec;
    string       name;
  } exp_t;

  logic       clk;
  logic       reset;
  logic [6:0] op;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic       Zero;
  logic       mem_ready;
  logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite;
  logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ImmSrc;
  logic [2:0] ALUControl;
  logic       illegal_instr, mem_fault;

  exp_t expQ[$];
  int   checks = 0;
  int   errors = 0;

  multicycle_controller #(.ALU_CTRL_W(3), .MEM_TIMEOUT(4)) dut (
    .clk           (clk),
    .reset         (reset),
    .op            (op),
    .funct3        (funct3),
    .funct7        (funct7),
    .Zero          (Zero),
    .mem_ready     (mem_ready),
    .PCWrite       (PCWrite),
    .AdrSrc        (AdrSrc),
    .MemWrite      (MemWrite),
    .IRWrite       (IRWrite),
    .RegWrite      (RegWrite),
    .ResultSrc     (ResultSrc),
    .ALUSrcA       (ALUSrcA),
    .ALUSrcB       (ALUSrcB),
    .ImmSrc        (ImmSrc),
    .ALUControl    (ALUControl),
    .illegal_instr (illegal_instr),
    .mem_fault     (mem_fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Packing order: PCWrite AdrSrc MemWrite IRWrite RegWrite ResultSrc ALUSrcA ALUSrcB ImmSrc ALUControl illegal fault
  function automatic logic [17:0] e(bit pcw, bit adr, bit mw, bit irw, bit rw, logic [1:0] rs,
                                    logic [1:0] sa, logic [1:0] sb, logic [1:0] im,
                                    logic [2:0] alu, bit ill, bit flt);
    return {pcw, adr, mw, irw, rw, rs, sa, sb, im, alu, ill, flt};
  endfunction

  function automatic logic [17:0] expFetch(logic [1:0] im, bit rdy, bit flt);
    return e(rdy, 0, 0, rdy, 0, 2'b10, 2'b00, 2'b10, im, 3'b010, 0, flt);
  endfunction

  function automatic logic [17:0] expDecode(logic [1:0] im, bit ill);
    return e(0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, im, 3'b010, ill, 0);
  endfunction

  function automatic logic [17:0] expMemadr(logic [1:0] im);
    return e(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, im, 3'b010, 0, 0);
  endfunction

  function automatic logic [17:0] expAluwb(logic [1:0] im);
    return e(0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, im, 3'b000, 0, 0);
  endfunction

  task automatic applyStimulus(input logic [6:0] o, input logic [2:0] f3, input logic [6:0] f7,
                               input logic z, input logic rdy, input logic rst,
                               input logic [17:0] v, input string nm);
    exp_t it;
    @(posedge clk);
    #1;
    op        = o;
    funct3    = f3;
    funct7    = f7;
    Zero      = z;
    mem_ready = rdy;
    reset     = rst;
    it.vec    = v;
    it.name   = nm;
    expQ.push_back(it);
  endtask

  task automatic checkOutput(input exp_t it);
    logic [17:0] act;
    act = {PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc, ALUSrcA, ALUSrcB,
           ImmSrc, ALUControl, illegal_instr, mem_fault};
    checks++;
    if (act !== it.vec) begin
      errors++;
      $display("[TB] FAIL %s: got %b expected %b", it.name, act, it.vec);
    end
  endtask

  always @(negedge clk) begin
    if (expQ.size() > 0)
      checkOutput(expQ.pop_front());
  end

  initial begin
    reset = 1'b1; op = LW; funct3 = 3'b010; funct7 = 7'd0; Zero = 1'b0; mem_ready = 1'b1;

    applyStimulus(LW, 3'b010, 7'd0, 0, 1, 1, e(0,0,0,0,0,2'b10,2'b00,2'b10,2'b00,3'b010,0,0), "reset");

    // lw with memory always ready
    applyStimulus(LW, 3'b010, 7'd0, 0, 1, 0, expFetch(2'b00, 1, 0), "lw.fetch");
    applyStimulus(LW, 3'b010, 7'd0, 0, 1, 0, expDecode(2'b00, 0), "lw.decode");
    applyStimulus(LW, 3'b010, 7'd0, 0, 1, 0, expMemadr(2'b00), "lw.memadr");
    applyStimulus(LW, 3'b010, 7'd0, 0, 1, 0, e(0,1,0,0,0,2'b00,2'b00,2'b00,2'b00,3'b000,0,0), "lw.memread");
    applyStimulus(LW, 3'b010, 7'd0, 0, 1, 0, e(0,0,0,0,1,2'b01,2'b00,2'b00,2'b00,3'b000,0,0), "lw.memwb");

    // sub and or (R-type)
    applyStimulus(RT, 3'b000, F7S, 0, 1, 0, expFetch(2'b00, 1, 0), "sub.fetch");
    applyStimulus(RT, 3'b000, F7S, 0, 1, 0, expDecode(2'b00, 0), "sub.decode");
    applyStimulus(RT, 3'b000, F7S, 0, 1, 0, e(0,0,0,0,0,2'b00,2'b10,2'b00,2'b00,3'b110,0,0), "sub.execr");
    applyStimulus(RT, 3'b000, F7S, 0, 1, 0, expAluwb(2'b00), "sub.aluwb");
    applyStimulus(RT, 3'b110, 7'd0, 0, 1, 0, expFetch(2'b00, 1, 0), "or.fetch");
    applyStimulus(RT, 3'b110, 7'd0, 0, 1, 0, expDecode(2'b00, 0), "or.decode");
    applyStimulus(RT, 3'b110, 7'd0, 0, 1, 0, e(0,0,0,0,0,2'b00,2'b10,2'b00,2'b00,3'b001,0,0), "or.execr");
    applyStimulus(RT, 3'b110, 7'd0, 0, 1, 0, expAluwb(2'b00), "or.aluwb");

    // I-type: funct7[5] must not turn addi into sub
    applyStimulus(IT, 3'b000, F7S, 0, 1, 0, expFetch(2'b00, 1, 0), "addi.fetch");
    applyStimulus(IT, 3'b000, F7S, 0, 1, 0, expDecode(2'b00, 0), "addi.decode");
    applyStimulus(IT, 3'b000, F7S, 0, 1, 0, e(0,0,0,0,0,2'b00,2'b10,2'b01,2'b00,3'b010,0,0), "addi.execi");
    applyStimulus(IT, 3'b000, F7S, 0, 1, 0, expAluwb(2'b00), "addi.aluwb");
    applyStimulus(IT, 3'b010, 7'd0, 0, 1, 0, expFetch(2'b00, 1, 0), "slti.fetch");
    applyStimulus(IT, 3'b010, 7'd0, 0, 1, 0, expDecode(2'b00, 0), "slti.decode");
    applyStimulus(IT, 3'b010, 7'd0, 0, 1, 0, e(0,0,0,0,0,2'b00,2'b10,2'b01,2'b00,3'b111,0,0), "slti.execi");
    applyStimulus(IT, 3'b010, 7'd0, 0, 1, 0, expAluwb(2'b00), "slti.aluwb");

    // beq taken and not taken
    applyStimulus(BR, 3'b000, 7'd0, 1, 1, 0, expFetch(2'b10, 1, 0), "beq1.fetch");
    applyStimulus(BR, 3'b000, 7'd0, 1, 1, 0, expDecode(2'b10, 0), "beq1.decode");
    applyStimulus(BR, 3'b000, 7'd0, 1, 1, 0, e(1,0,0,0,0,2'b00,2'b10,2'b00,2'b10,3'b110,0,0), "beq1.beq");
    applyStimulus(BR, 3'b000, 7'd0, 0, 1, 0, expFetch(2'b10, 1, 0), "beq0.fetch");
    applyStimulus(BR, 3'b000, 7'd0, 0, 1, 0, expDecode(2'b10, 0), "beq0.decode");
    applyStimulus(BR, 3'b000, 7'd0, 0, 1, 0, e(0,0,0,0,0,2'b00,2'b10,2'b00,2'b10,3'b110,0,0), "beq0.beq");

    // bne: inverse sense when enabled, illegal otherwise
    applyStimulus(BR, 3'b001, 7'd0, 0, 1, 0, expFetch(2'b10, 1, 0), "bne.fetch");
`ifdef CTRL_BNE_EN
    applyStimulus(BR, 3'b001, 7'd0, 0, 1, 0, expDecode(2'b10, 0), "bne0.decode");
    applyStimulus(BR, 3'b001, 7'd0, 0, 1, 0, e(1,0,0,0,0,2'b00,2'b10,2'b00,2'b10,3'b110,0,0), "bne0.beq");
    applyStimulus(BR, 3'b001, 7'd0, 1, 1, 0, expFetch(2'b10, 1, 0), "bne1.fetch");
    applyStimulus(BR, 3'b001, 7'd0, 1, 1, 0, expDecode(2'b10, 0), "bne1.decode");
    applyStimulus(BR, 3'b001, 7'd0, 1, 1, 0, e(0,0,0,0,0,2'b00,2'b10,2'b00,2'b10,3'b110,0,0), "bne1.beq");
`else
    applyStimulus(BR, 3'b001, 7'd0, 0, 1, 0, expDecode(2'b10, 1), "bne.illegal");
`endif

    // jal
    applyStimulus(JL, 3'b000, 7'd0, 0, 1, 0, expFetch(2'b11, 1, 0), "jal.fetch");
    applyStimulus(JL, 3'b000, 7'd0, 0, 1, 0, expDecode(2'b11, 0), "jal.decode");
    applyStimulus(JL, 3'b000, 7'd0, 0, 1, 0, e(1,0,0,0,0,2'b00,2'b01,2'b10,2'b11,3'b010,0,0), "jal.jal");
    applyStimulus(JL, 3'b000, 7'd0, 0, 1, 0, expAluwb(2'b11), "jal.aluwb");

    // unsupported opcode
    applyStimulus(SYS, 3'b000, 7'd0, 0, 1, 0, expFetch(2'b00, 1, 0), "sys.fetch");
    applyStimulus(SYS, 3'b000, 7'd0, 0, 1, 0, expDecode(2'b00, 1), "sys.decode");

    // sw with mem_ready low for 3 cycles: MemWrite for 4 cycles
    applyStimulus(SW, 3'b010, 7'd0, 0, 1, 0, expFetch(2'b01, 1, 0), "sw.fetch");
    applyStimulus(SW, 3'b010, 7'd0, 0, 1, 0, expDecode(2'b01, 0), "sw.decode");
    applyStimulus(SW, 3'b010, 7'd0, 0, 1, 0, expMemadr(2'b01), "sw.memadr");
    for (int i = 0; i < 3; i++)
      applyStimulus(SW, 3'b010, 7'd0, 0, 0, 0, e(0,1,1,0,0,2'b00,2'b00,2'b00,2'b01,3'b000,0,0), "sw.wait");
    applyStimulus(SW, 3'b010, 7'd0, 0, 1, 0, e(0,1,1,0,0,2'b00,2'b00,2'b00,2'b01,3'b000,0,0), "sw.done");

    // sw timing out after 4 waiting cycles: one fault pulse, no further MemWrite
    applyStimulus(SW, 3'b010, 7'd0, 0, 1, 0, expFetch(2'b01, 1, 0), "swto.fetch");
    applyStimulus(SW, 3'b010, 7'd0, 0, 1, 0, expDecode(2'b01, 0), "swto.decode");
    applyStimulus(SW, 3'b010, 7'd0, 0, 1, 0, expMemadr(2'b01), "swto.memadr");
    for (int i = 0; i < 4; i++)
      applyStimulus(SW, 3'b010, 7'd0, 0, 0, 0, e(0,1,1,0,0,2'b00,2'b00,2'b00,2'b01,3'b000,0,0), "swto.wait");
    applyStimulus(SW, 3'b010, 7'd0, 0, 0, 0, expFetch(2'b01, 0, 1), "swto.fault");
    applyStimulus(LW, 3'b010, 7'd0, 0, 1, 0, expFetch(2'b00, 1, 0), "swto.after");

    // lw: mem_ready arrives in the last allowed cycle, so no abort
    applyStimulus(LW, 3'b010, 7'd0, 0, 1, 0, expDecode(2'b00, 0), "tie.decode");
    applyStimulus(LW, 3'b010, 7'd0, 0, 1, 0, expMemadr(2'b00), "tie.memadr");
    for (int i = 0; i < 3; i++)
      applyStimulus(LW, 3'b010, 7'd0, 0, 0, 0, e(0,1,0,0,0,2'b00,2'b00,2'b00,2'b00,3'b000,0,0), "tie.wait");
    applyStimulus(LW, 3'b010, 7'd0, 0, 1, 0, e(0,1,0,0,0,2'b00,2'b00,2'b00,2'b00,3'b000,0,0), "tie.ready");
    applyStimulus(LW, 3'b010, 7'd0, 0, 1, 0, e(0,0,0,0,1,2'b01,2'b00,2'b00,2'b00,3'b000,0,0), "tie.memwb");

    // fetch timeout
    for (int i = 0; i < 4; i++)
      applyStimulus(LW, 3'b010, 7'd0, 0, 0, 0, expFetch(2'b00, 0, 0), "fto.wait");
    applyStimulus(LW, 3'b010, 7'd0, 0, 1, 0, expFetch(2'b00, 1, 1), "fto.fault");

    // reset asserted mid-read takes effect within the cycle
    applyStimulus(LW, 3'b010, 7'd0, 0, 1, 0, expDecode(2'b00, 0), "rst.decode");
    applyStimulus(LW, 3'b010, 7'd0, 0, 1, 0, expMemadr(2'b00), "rst.memadr");
    applyStimulus(LW, 3'b010, 7'd0, 0, 0, 0, e(0,1,0,0,0,2'b00,2'b00,2'b00,2'b00,3'b000,0,0), "rst.memread");
    applyStimulus(LW, 3'b010, 7'd0, 0, 1, 1, e(0,0,0,0,0,2'b10,2'b00,2'b10,2'b00,3'b010,0,0), "rst.async");
    applyStimulus(LW, 3'b010, 7'd0, 0, 1, 0, expFetch(2'b00, 1, 0), "rst.fetch");

    @(posedge clk);
    #1;
    if (expQ.size() != 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL drain: got %0d pending expected 0", expQ.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
